// File: rtl/rom_arb_pkg.sv
// ---------------------------------------------------------------------------
// rom_arb_pkg
// Shared types and constants for the instruction-ROM arbiter.
//   port_e       : requester identifiers (IF = 0, DR = 1); also used as the
//                  bit index into the 2-bit req/gnt vectors.
//   resp_state_e : per-port response register state (IDLE / VALID).
//   ROM_DEPTH_DEF, IDX_W_DEF : default geometry of the ROM.
//   ERR_RDATA    : read data returned with an error response.
//   STAT_W       : width of the optional statistics counters.
//   sat_inc()    : saturating increment for those counters.
// ---------------------------------------------------------------------------
package rom_arb_pkg;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_DR = 1'b1
   } port_e;

   typedef enum logic {
      RESP_IDLE  = 1'b0,
      RESP_VALID = 1'b1
   } resp_state_e;

   localparam int unsigned ROM_DEPTH_DEF = 32;
   localparam int unsigned IDX_W_DEF     = 8;
   localparam logic [31:0] ERR_RDATA     = 32'h0;
   localparam int unsigned STAT_W        = 16;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter with a 1-bit last-grant pointer.
//   clk   in   system clock, rising edge
//   reset in   asynchronous, active-low reset (pointer -> PORT_DR)
//   stall in   suppresses all grants this cycle
//   req   in   [PORT_IF] / [PORT_DR] requests
//   gnt   out  one-hot (or zero) combinational grant
// The pointer moves only when a grant is issued, so idle and stalled cycles
// leave the round-robin order untouched.
// ---------------------------------------------------------------------------
module rr_arb2
   import rom_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       stall,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   port_e r_last;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      gnt = 2'b00;
      if (!stall) begin
         if (req[PORT_IF] && req[PORT_DR]) begin
            // Conflict: the port that did not win last time goes now.
            if (r_last == PORT_DR) gnt[PORT_IF] = 1'b1;
            else                   gnt[PORT_DR] = 1'b1;
         end else begin
            gnt = req;
         end
      end
   end

   // Reset value PORT_DR makes IF the winner of the first conflict.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (!reset)              r_last <= PORT_DR;
      else if (gnt[PORT_IF])   r_last <= PORT_IF;
      else if (gnt[PORT_DR])   r_last <= PORT_DR;
   end

endmodule

// File: rtl/rom_arbiter.sv
// ---------------------------------------------------------------------------
// rom_arbiter
// Shares one combinational instruction ROM between instruction fetch (IF)
// and a data-read port (DR, also used by the debug loader). One grant per
// cycle, round-robin on conflict, registered response one cycle after grant.
//
// Ports:
//   clk, reset            clock / async active-low reset
//   stall                 blocks new grants (pending responses still emerge)
//   if_req, if_addr       IF request, byte address held until if_gnt
//   if_gnt                IF accepted this cycle (combinational)
//   if_rvalid/rdata/err   IF one-cycle response pulse, err qualified by rvalid
//   dr_*                  same set for the DR port
//   rom_addr              granted requester's address, 0 when idle
//   rom_data              combinational ROM data for rom_addr
//   stat_*_cnt            (ROM_ARB_STATS_EN only) saturating 16-bit counters
//
// Build option: define ROM_ARB_STATS_EN to add the statistics counters and
// their output ports; without it the block is otherwise identical.
// ---------------------------------------------------------------------------
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
   parameter int unsigned IDX_W     = IDX_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        dr_req,
   input  logic [31:0] dr_addr,
   output logic        dr_gnt,
   output logic        dr_rvalid,
   output logic [31:0] dr_rdata,
   output logic        dr_err,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data
`ifdef ROM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_if_cnt,
   output logic [STAT_W-1:0] stat_dr_cnt,
   output logic [STAT_W-1:0] stat_conflict_cnt
`endif
);

   // Misaligned, high bits above the index field set, or index past the end.
   function automatic logic addr_err(input logic [31:0] a);
      logic [IDX_W-1:0] idx;
      idx = a[IDX_W+1:2];
      return (a[1:0] != 2'b00) || (a[31:IDX_W+2] != '0) || (32'(idx) >= ROM_DEPTH);
   endfunction

   logic [1:0]  w_req;
   logic [1:0]  w_gnt;
   logic        w_err;
   logic [31:0] w_rdata;

   resp_state_e r_if_state;
   resp_state_e r_dr_state;
   logic [31:0] r_if_rdata;
   logic [31:0] r_dr_rdata;
   logic        r_if_err;
   logic        r_dr_err;

   assign w_req[PORT_IF] = if_req;
   assign w_req[PORT_DR] = dr_req;

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .reset (reset),
      .stall (stall),
      .req   (w_req),
      .gnt   (w_gnt)
   );

   assign if_gnt   = w_gnt[PORT_IF];
   assign dr_gnt   = w_gnt[PORT_DR];
   assign rom_addr = if_gnt ? if_addr : (dr_gnt ? dr_addr : 32'h0);

   // One checker suffices: only the granted address reaches rom_addr.
   assign w_err   = addr_err(rom_addr);
   assign w_rdata = w_err ? ERR_RDATA : rom_data;

   // Response registers: VALID for exactly the cycle after a grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_if_state <= RESP_IDLE;
         r_dr_state <= RESP_IDLE;
         r_if_rdata <= '0;
         r_dr_rdata <= '0;
         r_if_err   <= 1'b0;
         r_dr_err   <= 1'b0;
      end else begin
         r_if_state <= if_gnt ? RESP_VALID : RESP_IDLE;
         r_dr_state <= dr_gnt ? RESP_VALID : RESP_IDLE;
         r_if_err   <= if_gnt & w_err;
         r_dr_err   <= dr_gnt & w_err;
         if (if_gnt) r_if_rdata <= w_rdata;
         if (dr_gnt) r_dr_rdata <= w_rdata;
      end
   end

   assign if_rvalid = (r_if_state == RESP_VALID);
   assign dr_rvalid = (r_dr_state == RESP_VALID);
   assign if_rdata  = r_if_rdata;
   assign dr_rdata  = r_dr_rdata;
   assign if_err    = r_if_err;
   assign dr_err    = r_dr_err;

`ifdef ROM_ARB_STATS_EN
   logic [STAT_W-1:0] r_stat_if;
   logic [STAT_W-1:0] r_stat_dr;
   logic [STAT_W-1:0] r_stat_conflict;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_if       <= '0;
         r_stat_dr       <= '0;
         r_stat_conflict <= '0;
      end else begin
         if (if_gnt)                     r_stat_if       <= sat_inc(r_stat_if);
         if (dr_gnt)                     r_stat_dr       <= sat_inc(r_stat_dr);
         if (if_req && dr_req && !stall) r_stat_conflict <= sat_inc(r_stat_conflict);
      end
   end

   assign stat_if_cnt       = r_stat_if;
   assign stat_dr_cnt       = r_stat_dr;
   assign stat_conflict_cnt = r_stat_conflict;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_arbiter
// Table-driven bench for rom_arbiter. Each vector drives one cycle of
// requests and states the expected grants; the expected response for that
// cycle is pushed to a queue and compared one cycle later. A hand-written
// sequence covers reset asserted while a response is on the outputs.
// ---------------------------------------------------------------------------
module tb_rom_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        dr_req;
   logic [31:0] dr_addr;
   logic        dr_gnt;
   logic        dr_rvalid;
   logic [31:0] dr_rdata;
   logic        dr_err;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        stall;
      logic        if_req;
      logic [31:0] if_addr;
      logic        dr_req;
      logic [31:0] dr_addr;
      logic        if_gnt;
      logic        dr_gnt;
   } vec_t;

   typedef struct {
      logic        if_v;
      logic [31:0] if_d;
      logic        if_e;
      logic        dr_v;
      logic [31:0] dr_d;
      logic        dr_e;
   } resp_t;

   resp_t sb[$];

   localparam int NVEC = 19;
   vec_t vecs[NVEC];

   rom_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .dr_req    (dr_req),
      .dr_addr   (dr_addr),
      .dr_gnt    (dr_gnt),
      .dr_rvalid (dr_rvalid),
      .dr_rdata  (dr_rdata),
      .dr_err    (dr_err),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data)
   );

   always #5 clk = ~clk;

   // Bench ROM: known words at 0, 1, 4; distinct nonzero filler elsewhere
   // (also beyond the valid range, so a zeroed error response is visible).
   function automatic logic [31:0] rom_word(input logic [31:0] idx);
      case (idx)
         32'd0:   return 32'h3C04_4000;
         32'd1:   return 32'h2484_000C;
         32'd4:   return 32'h0800_0004;
         default: return 32'hC0DE_0000 ^ idx;
      endcase
   endfunction

   assign rom_data = rom_word({2'b00, rom_addr[31:2]});

   // 32 valid words of 4 bytes: any aligned address >= 128 is out of range.
   function automatic logic bad_addr(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'd128);
   endfunction

   function automatic vec_t mk(input logic s, input logic ir, input logic [31:0] ia,
                               input logic dq, input logic [31:0] da,
                               input logic eig, input logic edg);
      vec_t v;
      v.stall = s;  v.if_req = ir; v.if_addr = ia;
      v.dr_req = dq; v.dr_addr = da; v.if_gnt = eig; v.dr_gnt = edg;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_resp(input resp_t e);
      check("if_rvalid", if_rvalid, e.if_v);
      check("dr_rvalid", dr_rvalid, e.dr_v);
      if (e.if_v) begin
         check("if_rdata", if_rdata, e.if_d);
         check("if_err",   if_err,   e.if_e);
      end
      if (e.dr_v) begin
         check("dr_rdata", dr_rdata, e.dr_d);
         check("dr_err",   dr_err,   e.dr_e);
      end
   endtask

   // One cycle: check the response owed from the previous cycle, drive the
   // new inputs, check grants/rom_addr, and queue the response now owed.
   task automatic step(input vec_t v);
      resp_t       e;
      logic [31:0] exp_addr;
      @(negedge clk);
      if (sb.size() > 0) compare_resp(sb.pop_front());
      stall   = v.stall;
      if_req  = v.if_req;
      if_addr = v.if_addr;
      dr_req  = v.dr_req;
      dr_addr = v.dr_addr;
      #1;
      check("if_gnt", if_gnt, v.if_gnt);
      check("dr_gnt", dr_gnt, v.dr_gnt);
      exp_addr = v.if_gnt ? v.if_addr : (v.dr_gnt ? v.dr_addr : 32'h0);
      check("rom_addr", rom_addr, exp_addr);
      e.if_v = v.if_gnt;
      e.if_e = bad_addr(v.if_addr);
      e.if_d = e.if_e ? 32'h0 : rom_word(v.if_addr >> 2);
      e.dr_v = v.dr_gnt;
      e.dr_e = bad_addr(v.dr_addr);
      e.dr_d = e.dr_e ? 32'h0 : rom_word(v.dr_addr >> 2);
      sb.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      resp_t idle_resp;
      idle_resp = '{if_v: 1'b0, if_d: 32'h0, if_e: 1'b0, dr_v: 1'b0, dr_d: 32'h0, dr_e: 1'b0};

      //              stall ifr  if_addr       drr  dr_addr       ifg  drg
      vecs[0]  = mk(1'b0, 1'b1, 32'h10,  1'b1, 32'h4,  1'b1, 1'b0); // first conflict -> IF
      vecs[1]  = mk(1'b0, 1'b1, 32'h10,  1'b1, 32'h4,  1'b0, 1'b1); // then DR
      vecs[2]  = mk(1'b0, 1'b1, 32'h10,  1'b1, 32'h4,  1'b1, 1'b0); // then IF again
      vecs[3]  = mk(1'b0, 1'b1, 32'h0,   1'b0, 32'h0,  1'b1, 1'b0); // IF alone, word0
      vecs[4]  = mk(1'b0, 1'b1, 32'h4,   1'b0, 32'h0,  1'b1, 1'b0); // IF alone, word1
      vecs[5]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h6,  1'b0, 1'b1); // misaligned DR
      vecs[6]  = mk(1'b0, 1'b1, 32'h80,  1'b0, 32'h0,  1'b1, 1'b0); // index 32
      vecs[7]  = mk(1'b0, 1'b1, 32'h400, 1'b0, 32'h0,  1'b1, 1'b0); // high bits set
      vecs[8]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h7C, 1'b0, 1'b1); // last valid word
      vecs[9]  = mk(1'b1, 1'b1, 32'h0,   1'b1, 32'h4,  1'b0, 1'b0); // stall x3
      vecs[10] = mk(1'b1, 1'b1, 32'h0,   1'b1, 32'h4,  1'b0, 1'b0);
      vecs[11] = mk(1'b1, 1'b1, 32'h0,   1'b1, 32'h4,  1'b0, 1'b0);
      vecs[12] = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h4,  1'b1, 1'b0); // pointer held -> IF
      vecs[13] = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h4,  1'b0, 1'b1);
      vecs[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0,  1'b0, 1'b1); // DR alone every cycle
      vecs[15] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h4,  1'b0, 1'b1);
      vecs[16] = mk(1'b0, 1'b1, 32'h4,   1'b0, 32'h0,  1'b1, 1'b0);
      vecs[17] = mk(1'b1, 1'b1, 32'h0,   1'b1, 32'h0,  1'b0, 1'b0); // stall, IF resp pending
      vecs[18] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0);

      reset   = 1'b0;
      stall   = 1'b0;
      if_req  = 1'b0;
      if_addr = 32'h0;
      dr_req  = 1'b0;
      dr_addr = 32'h0;
      #12;
      compare_resp(idle_resp);
      check("if_rdata_rst", if_rdata, 32'h0);
      check("dr_rdata_rst", dr_rdata, 32'h0);
      check("if_err_rst",   if_err,   1'b0);
      check("dr_err_rst",   dr_err,   1'b0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < NVEC; i++) step(vecs[i]);

      // Grant IF, then assert reset while its response is on the outputs.
      step(mk(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0));
      @(posedge clk);
      #2;
      check("if_rvalid_before_reset", if_rvalid, 1'b1);
      if_req = 1'b0;
      dr_req = 1'b0;
      reset  = 1'b0;
      #1;
      check("if_rvalid_in_reset", if_rvalid, 1'b0);
      check("if_rdata_in_reset",  if_rdata,  32'h0);
      sb.delete();
      sb.push_back(idle_resp);
      @(negedge clk);
      reset = 1'b1;

      // No response after release; first conflict goes to IF again.
      step(mk(1'b0, 1'b1, 32'h10, 1'b1, 32'h4, 1'b1, 1'b0));
      step(mk(1'b0, 1'b1, 32'h10, 1'b1, 32'h4, 1'b0, 1'b1));
      step(mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0));
      @(negedge clk);
      while (sb.size() > 0) compare_resp(sb.pop_front());

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
